// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame scheduler.
`timescale 1ns/1ps
package uart_pkg;
  localparam int unsigned BYTE_W = 8;
  localparam logic [7:0] HEADER_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, HDR, ID, PAY, CSUM, GAP, FIN
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       idx,
  output logic             valid
);
  // Two passes: indices >= ptr first, then the wrapped-around low indices.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!valid && req[j] && (3'(j) >= ptr)) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = 3'(j);
      end
    end
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = 3'(j);
      end
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART TX FIFO between requesters, emitting
// header / id / payload / checksum frames with one idle cycle after each write.
`timescale 1ns/1ps
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned PAYLOAD_BYTES = 2,
  parameter logic [7:0]  HEADER        = HEADER_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    req,
  input  logic [N_REQ*PAYLOAD_BYTES*8-1:0]    payload,
  input  logic                                tx_full,
  output logic [7:0]                          w_data,
  output logic                                wr_uart,
  output logic [N_REQ-1:0]                    gnt,
  output logic [N_REQ-1:0]                    done,
  output logic                                busy
);
  localparam int unsigned PW = PAYLOAD_BYTES * BYTE_W;

  state_t           state_q, state_n, last_q, last_n;
  logic [2:0]       idx_q, idx_n, gidx_q, gidx_n, ptr_q, ptr_n;
  logic [PW-1:0]    pay_q, pay_n, pay_sel;
  logic [7:0]       csum_q, csum_n, w_data_n, cur_byte;
  logic             wr_n, busy_n;
  logic [N_REQ-1:0] gnt_n, done_n, arb_gnt;
  logic [2:0]       arb_idx;
  logic             arb_valid;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    pay_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) pay_sel = payload[i*PW +: PW];
    end
  end

  // Latched payload shifts left per byte sent, so the MSB byte is always current.
  always_comb begin
    case (state_q)
      HDR:     cur_byte = HEADER;
      ID:      cur_byte = {5'b0, gidx_q};
      PAY:     cur_byte = pay_q[PW-1 -: 8];
      CSUM:    cur_byte = csum_q;
      default: cur_byte = '0;
    endcase
  end

  always_comb begin
    state_n  = state_q;
    last_n   = last_q;
    idx_n    = idx_q;
    gidx_n   = gidx_q;
    ptr_n    = ptr_q;
    pay_n    = pay_q;
    csum_n   = csum_q;
    w_data_n = w_data;
    wr_n     = 1'b0;
    gnt_n    = gnt;
    done_n   = '0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_n   = arb_gnt;
          gidx_n  = arb_idx;
          pay_n   = pay_sel;
          idx_n   = '0;
          csum_n  = '0;
          state_n = HDR;
        end
      end
      HDR, ID, PAY, CSUM: begin
        if (!tx_full) begin
          w_data_n = cur_byte;
          wr_n     = 1'b1;
          last_n   = state_q;
          state_n  = GAP;
          if (state_q == ID) begin
            csum_n = cur_byte;
          end else if (state_q == PAY) begin
            csum_n = csum_q + cur_byte;
            pay_n  = pay_q << BYTE_W;
          end
        end
      end
      GAP: begin
        case (last_q)
          HDR: state_n = ID;
          ID:  state_n = PAY;
          PAY: begin
            if (idx_q == 3'(PAYLOAD_BYTES - 1)) begin
              state_n = CSUM;
            end else begin
              idx_n   = idx_q + 3'd1;
              state_n = PAY;
            end
          end
          default: state_n = FIN;
        endcase
      end
      FIN: begin
        done_n  = gnt;
        gnt_n   = '0;
        ptr_n   = (gidx_q == 3'(N_REQ - 1)) ? 3'd0 : gidx_q + 3'd1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDLE;
      idx_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      pay_q   <= '0;
      csum_q  <= '0;
      w_data  <= '0;
      wr_uart <= 1'b0;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      last_q  <= last_n;
      idx_q   <= idx_n;
      gidx_q  <= gidx_n;
      ptr_q   <= ptr_n;
      pay_q   <= pay_n;
      csum_q  <= csum_n;
      w_data  <= w_data_n;
      wr_uart <= wr_n;
      gnt     <= gnt_n;
      done    <= done_n;
      busy    <= busy_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with two requesters and two-byte payloads.
`timescale 1ns/1ps
module tb_uart_tx_sched;
  logic        clk = 1'b0;
  logic        rst, tx_full, wr_uart, busy;
  logic [1:0]  req, gnt, done;
  logic [31:0] payload;
  logic [7:0]  w_data;

  int unsigned n_tests = 0, n_fail = 0;
  int unsigned b2b_viol = 0, full_viol = 0, gnt_viol = 0, done_cnt = 0;
  logic        prev_wr = 1'b0, full_at_edge = 1'b0;

  always #5 clk = ~clk;

  uart_tx_sched #(.N_REQ(2), .PAYLOAD_BYTES(2), .HEADER(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .payload (payload),
    .tx_full (tx_full),
    .w_data  (w_data),
    .wr_uart (wr_uart),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs only change at negedge, so tx_full here is what the DUT sampled.
  always @(posedge clk) full_at_edge = tx_full;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_uart && prev_wr) b2b_viol++;
      if (wr_uart && full_at_edge) full_viol++;
      if (!$onehot0(gnt)) gnt_viol++;
    end
    if (done != 2'b00) done_cnt++;
    prev_wr = wr_uart;
  end

  task automatic get_byte(output logic [7:0] b, output int unsigned waited);
    b = '0;
    waited = 0;
    for (int unsigned k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (wr_uart) begin
        b = w_data;
        waited = k;
        return;
      end
    end
    check_eq("write_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input string name, input logic [39:0] frame, input logic [1:0] exp_gnt);
    logic [7:0]  b;
    int unsigned w;
    for (int i = 0; i < 5; i++) begin
      get_byte(b, w);
      check_eq($sformatf("%s_byte%0d", name, i), {24'd0, b}, {24'd0, frame[39-8*i -: 8]});
      if (i > 0) check_eq($sformatf("%s_gap%0d", name, i), w, 32'd2);
      if (i == 0) check_eq($sformatf("%s_gnt", name), {30'd0, gnt}, {30'd0, exp_gnt});
    end
  endtask

  task automatic wait_done(input string name, input logic [1:0] exp, input bit drop);
    for (int unsigned k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done != 2'b00) break;
    end
    check_eq($sformatf("%s_done", name), {30'd0, done}, {30'd0, exp});
    check_eq($sformatf("%s_gnt_clr", name), {30'd0, gnt}, 32'd0);
    check_eq($sformatf("%s_busy_clr", name), {31'd0, busy}, 32'd0);
    if (drop) req = 2'b00;
    @(negedge clk);
    check_eq($sformatf("%s_done_1cyc", name), {30'd0, done}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq($sformatf("%s_w_data", name), {24'd0, w_data}, 32'd0);
    check_eq($sformatf("%s_wr_uart", name), {31'd0, wr_uart}, 32'd0);
    check_eq($sformatf("%s_gnt", name), {30'd0, gnt}, 32'd0);
    check_eq($sformatf("%s_done", name), {30'd0, done}, 32'd0);
    check_eq($sformatf("%s_busy", name), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    int unsigned w, stall_writes;

    rst = 1'b1; req = 2'b00; payload = '0; tx_full = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single frame from requester 0
    payload[15:0] = 16'h1234;
    req = 2'b01;
    run_frame("single", 40'hA5_00_12_34_46, 2'b01);
    wait_done("single", 2'b01, 1'b1);

    // Checksum wrap on requester 1
    payload[31:16] = 16'hFFFF;
    req = 2'b10;
    run_frame("wrap", 40'hA5_01_FF_FF_FF, 2'b10);
    wait_done("wrap", 2'b10, 1'b1);

    // Round-robin from reset with both requests held
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    run_frame("rr0", 40'hA5_00_12_34_46, 2'b01);
    wait_done("rr0", 2'b01, 1'b0);
    run_frame("rr1", 40'hA5_01_FF_FF_FF, 2'b10);
    wait_done("rr1", 2'b10, 1'b0);
    run_frame("rr2", 40'hA5_00_12_34_46, 2'b01);
    wait_done("rr2", 2'b01, 1'b1);

    // Backpressure while the ID byte is pending
    req = 2'b01;
    get_byte(b, w);
    check_eq("bp_byte0", {24'd0, b}, 32'hA5);
    tx_full = 1'b1;
    stall_writes = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_uart) stall_writes++;
    end
    check_eq("bp_no_write", stall_writes, 32'd0);
    check_eq("bp_busy", {31'd0, busy}, 32'd1);
    tx_full = 1'b0;
    get_byte(b, w);
    check_eq("bp_byte1", {24'd0, b}, 32'h00);
    check_eq("bp_resume_lat", w, 32'd1);
    get_byte(b, w);
    check_eq("bp_byte2", {24'd0, b}, 32'h12);
    get_byte(b, w);
    check_eq("bp_byte3", {24'd0, b}, 32'h34);
    get_byte(b, w);
    check_eq("bp_byte4", {24'd0, b}, 32'h46);
    wait_done("bp", 2'b01, 1'b1);

    // Reset in the middle of the payload
    req = 2'b01;
    get_byte(b, w);
    check_eq("mid_byte0", {24'd0, b}, 32'hA5);
    get_byte(b, w);
    check_eq("mid_byte1", {24'd0, b}, 32'h00);
    get_byte(b, w);
    check_eq("mid_byte2", {24'd0, b}, 32'h12);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_frame("restart", 40'hA5_00_12_34_46, 2'b01);
    wait_done("restart", 2'b01, 1'b1);

    // Payload changes after grant must not affect the frame
    payload[15:0] = 16'h1234;
    req = 2'b01;
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      if (gnt != 2'b00) break;
    end
    check_eq("latch_gnt_seen", {30'd0, gnt}, 32'd1);
    payload[15:0] = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      get_byte(b, w);
      case (i)
        0: check_eq("latch_byte0", {24'd0, b}, 32'hA5);
        1: check_eq("latch_byte1", {24'd0, b}, 32'h00);
        2: check_eq("latch_byte2", {24'd0, b}, 32'h12);
        3: check_eq("latch_byte3", {24'd0, b}, 32'h34);
        default: check_eq("latch_byte4", {24'd0, b}, 32'h46);
      endcase
    end
    wait_done("latch", 2'b01, 1'b1);

    repeat (3) @(negedge clk);
    check_eq("wr_back_to_back", b2b_viol, 32'd0);
    check_eq("wr_while_full", full_viol, 32'd0);
    check_eq("gnt_onehot", gnt_viol, 32'd0);
    check_eq("done_pulse_total", done_cnt, 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
